// File: rtl/tx.sv
// Per-square relay transmitter: seeds the square's own piece in all 16 directions, then
// scans rx and re-emits continuing sliding pieces toward the opposite neighbour.
module tx (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         start_i,
    input  logic         step_i,
    input  logic         hold_i,
    input  logic [9:0]   square_piece_i,
    input  logic         square_mine_i,
    input  logic         rx_tx_valid_i,
    input  logic [9:0]   rx_tx_piece_i,
    output logic [3:0]   direction_idx_o,
    output logic [159:0] moves_out_o,
    output logic         busy_o,
    output logic         scan_done_o,
    output logic         relay_any_o
);

    typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

    state_e         state_q, state_d;
    logic [3:0]     dir_q, dir_d;
    logic [159:0]   moves_q, moves_d;
    logic [159:0]   shadow_q, shadow_d;
    logic [3:0]     opp_dir;
    logic [7:0]     slot_lsb;

    // Sliding directions pair up by flipping bit 1 (0<->2, 1<->3, 4<->6, 5<->7).
    assign opp_dir  = dir_q ^ 4'd2;
    assign slot_lsb = 8'(opp_dir) * 8'd10;

    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        moves_d  = moves_q;
        shadow_d = shadow_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    if (square_mine_i && (square_piece_i != 10'd0)) begin
                        moves_d = {16{square_piece_i}};
                    end else begin
                        moves_d = '0;
                    end
                end else if (step_i) begin
                    state_d  = StScan;
                    dir_d    = 4'd0;
                    shadow_d = '0;
                end
            end
            StScan: begin
                if (!hold_i) begin
                    // Knight directions (8-15) never relay.
                    if (!dir_q[3] && rx_tx_valid_i) begin
                        shadow_d[slot_lsb +: 10] = rx_tx_piece_i;
                    end
                    if (dir_q == 4'd15) begin
                        state_d = StDone;
                        dir_d   = 4'd0;
                        moves_d = shadow_q;
                    end else begin
                        dir_d = dir_q + 4'd1;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            dir_q    <= 4'd0;
            moves_q  <= '0;
            shadow_q <= '0;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            moves_q  <= moves_d;
            shadow_q <= shadow_d;
        end
    end

    assign direction_idx_o = dir_q;
    assign moves_out_o     = moves_q;
    assign busy_o          = (state_q != StIdle);
    assign scan_done_o     = (state_q == StDone);
    assign relay_any_o     = |moves_q;

endmodule

// File: tb/tb_tx.sv
// Directed self-checking bench for tx; rx is modelled as a small combinational lookup on
// direction_idx selected by rx_mode.
module tb_tx;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         step;
    logic         hold;
    logic [9:0]   square_piece;
    logic         square_mine;
    logic         rx_tx_valid;
    logic [9:0]   rx_tx_piece;
    logic [3:0]   direction_idx;
    logic [159:0] moves_out;
    logic         busy;
    logic         scan_done;
    logic         relay_any;

    int n_checks = 0;
    int n_errors = 0;
    int rx_mode  = 0;
    int edges;

    logic [159:0] seed_1a5;
    logic [159:0] relay_exp;
    logic [159:0] hold_exp;

    tx dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .start_i         (start),
        .step_i          (step),
        .hold_i          (hold),
        .square_piece_i  (square_piece),
        .square_mine_i   (square_mine),
        .rx_tx_valid_i   (rx_tx_valid),
        .rx_tx_piece_i   (rx_tx_piece),
        .direction_idx_o (direction_idx),
        .moves_out_o     (moves_out),
        .busy_o          (busy),
        .scan_done_o     (scan_done),
        .relay_any_o     (relay_any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // rx model: mode 1 relay, mode 2 knight-only, mode 3 hold test.
    always_comb begin
        rx_tx_valid = 1'b0;
        rx_tx_piece = 10'd0;
        case (rx_mode)
            1: begin
                if (direction_idx == 4'd0) begin
                    rx_tx_valid = 1'b1;
                    rx_tx_piece = 10'h0C3;
                end else if (direction_idx == 4'd5) begin
                    rx_tx_valid = 1'b1;
                    rx_tx_piece = 10'h0D1;
                end
            end
            2: begin
                if (direction_idx >= 4'd8) begin
                    rx_tx_valid = 1'b1;
                    rx_tx_piece = 10'h2FF;
                end
            end
            3: begin
                if (direction_idx == 4'd4) begin
                    rx_tx_valid = 1'b1;
                    rx_tx_piece = 10'h0C3;
                end
            end
            default: ;
        endcase
    end

    task automatic check_eq(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges (starting from base) until scan_done is seen, bounded.
    task automatic wait_done(input int base, output int n);
        n = base;
        do begin
            tick();
            n++;
        end while (!scan_done && n < base + 40);
    endtask

    task automatic seed(input logic [9:0] piece, input logic mine);
        square_piece = piece;
        square_mine  = mine;
        start        = 1'b1;
        tick();
        start        = 1'b0;
    endtask

    initial begin
        seed_1a5  = {16{10'h1A5}};
        relay_exp = '0;
        relay_exp[29:20] = 10'h0C3;
        relay_exp[79:70] = 10'h0D1;
        hold_exp  = '0;
        hold_exp[69:60]  = 10'h0C3;

        rst_n = 1'b0; start = 1'b0; step = 1'b0; hold = 1'b0;
        square_piece = 10'd0; square_mine = 1'b0;
        #3;
        check_eq("rst_moves", moves_out, '0);
        check_eq("rst_idx", 160'(direction_idx), 160'd0);
        check_eq("rst_busy", 160'(busy), 160'd0);
        check_eq("rst_done", 160'(scan_done), 160'd0);
        check_eq("rst_relay_any", 160'(relay_any), 160'd0);
        #4 rst_n = 1'b1;
        tick();

        // Seed, mine and not mine.
        seed(10'h1A5, 1'b1);
        check_eq("seed_moves", moves_out, seed_1a5);
        check_eq("seed_relay_any", 160'(relay_any), 160'd1);
        check_eq("seed_busy", 160'(busy), 160'd0);
        seed(10'h1A5, 1'b0);
        check_eq("seed_notmine_moves", moves_out, '0);
        check_eq("seed_notmine_relay_any", 160'(relay_any), 160'd0);

        // Relay scan with mid-scan start/step collisions.
        seed(10'h1A5, 1'b1);
        rx_mode = 1;
        step = 1'b1;
        tick();
        step = 1'b0;
        check_eq("relay_busy", 160'(busy), 160'd1);
        check_eq("relay_idx0", 160'(direction_idx), 160'd0);
        repeat (5) tick();
        check_eq("relay_idx5", 160'(direction_idx), 160'd5);
        square_piece = 10'h155;
        start = 1'b1;
        step  = 1'b1;
        tick();
        start = 1'b0;
        step  = 1'b0;
        check_eq("midscan_moves_stable", moves_out, seed_1a5);
        check_eq("midscan_busy", 160'(busy), 160'd1);
        wait_done(6, edges);
        check_eq("relay_done_edges", 160'(edges), 160'd16);
        check_eq("relay_moves", moves_out, relay_exp);
        check_eq("relay_relay_any", 160'(relay_any), 160'd1);
        tick();
        check_eq("relay_done_pulse", 160'(scan_done), 160'd0);
        check_eq("relay_idle_busy", 160'(busy), 160'd0);
        check_eq("relay_moves_held", moves_out, relay_exp);
        tick();
        check_eq("no_queued_step", 160'(busy), 160'd0);

        // Knight directions must never relay.
        rx_mode = 2;
        step = 1'b1;
        tick();
        step = 1'b0;
        wait_done(0, edges);
        check_eq("knight_done_edges", 160'(edges), 160'd16);
        check_eq("knight_moves", moves_out, '0);
        check_eq("knight_relay_any", 160'(relay_any), 160'd0);
        tick();

        // Hold for three cycles at idx 4.
        rx_mode = 3;
        step = 1'b1;
        tick();
        step = 1'b0;
        repeat (4) tick();
        check_eq("hold_idx_a", 160'(direction_idx), 160'd4);
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("hold_idx_b", 160'(direction_idx), 160'd4);
        end
        hold = 1'b0;
        tick();
        check_eq("hold_idx_after", 160'(direction_idx), 160'd5);
        check_eq("hold_moves_stable", moves_out, '0);
        wait_done(8, edges);
        check_eq("hold_done_edges", 160'(edges), 160'd19);
        check_eq("hold_moves", moves_out, hold_exp);
        tick();

        // start and step together: seed only.
        square_piece = 10'h1A5;
        square_mine  = 1'b1;
        start = 1'b1;
        step  = 1'b1;
        tick();
        start = 1'b0;
        step  = 1'b0;
        check_eq("both_moves", moves_out, seed_1a5);
        check_eq("both_busy", 160'(busy), 160'd0);
        tick();
        check_eq("both_busy_later", 160'(busy), 160'd0);

        // Reset mid-scan at idx 6.
        rx_mode = 1;
        step = 1'b1;
        tick();
        step = 1'b0;
        repeat (6) tick();
        check_eq("prereset_idx", 160'(direction_idx), 160'd6);
        #2 rst_n = 1'b0;
        #1;
        check_eq("midrst_moves", moves_out, '0);
        check_eq("midrst_idx", 160'(direction_idx), 160'd0);
        check_eq("midrst_busy", 160'(busy), 160'd0);
        check_eq("midrst_done", 160'(scan_done), 160'd0);
        #2 rst_n = 1'b1;
        tick();
        check_eq("postrst_busy", 160'(busy), 160'd0);
        step = 1'b1;
        tick();
        step = 1'b0;
        wait_done(0, edges);
        check_eq("postrst_done_edges", 160'(edges), 160'd16);
        check_eq("postrst_moves", moves_out, relay_exp);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tx.md
# tx

Per-square relay transmitter for the move generator; the sending side of the neighbour-to-neighbour piece exchange whose receiving side is `rx`. It seeds the square's own piece outward in all 16 directions (8 slide, 8 knight). It then scans `direction_idx` through `rx` and captures sliding pieces that `rx` reports as continuing (`rx_tx_valid`). It re-emits each captured piece toward the opposite neighbour, one hop per scan.

## Interface
- No parameters.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  seed request; sampled in IDLE only.
- `step`  in  1  relay-scan request; sampled in IDLE only.
- `hold`  in  1  freezes the scan (stack backpressure).
- `square_piece`  in  10  piece on this square; 10'd0 = empty.
- `square_mine`  in  1  square_piece belongs to side to move.
- `rx_tx_valid`  in  1  from rx: piece at current direction continues sliding.
- `rx_tx_piece`  in  10  from rx: piece at current direction.
- `direction_idx`  out  4  direction select driven to rx.
- `moves_out`  out  160  slot i = bits [10i+9:10i], piece sent toward neighbour i; 0 = none.
- `busy`  out  1  high in SCAN and DONE.
- `scan_done`  out  1  one-cycle pulse in DONE.
- `relay_any`  out  1  OR of nonzero slots of current `moves_out`.

## Operation
- Direction numbering:
  - 0 up, 1 right, 2 down, 3 left.
  - 4 up-left, 5 up-right, 6 down-right, 7 down-left.
  - 8–15 are knight directions.
- Opposite map: 0↔2, 1↔3, 4↔6, 5↔7.
- States: IDLE, SCAN, DONE. Reset state is IDLE.
- IDLE, `start`=1 → all 16 slots of `moves_out` are loaded at that edge.
  - Load value: `square_piece` if `square_mine`=1 and `square_piece`≠0, else 0.
  - State stays IDLE.
- IDLE, `step`=1 (and `start`=0) → SCAN.
  - `direction_idx`←0.
  - 160-bit shadow register←0.
  - `start` has priority over `step` when both are high.
- SCAN, each edge with `hold`=0:
  - If `direction_idx`<8 and `rx_tx_valid`=1, shadow slot opposite(`direction_idx`)←`rx_tx_piece`.
  - Then `direction_idx` increments.
- SCAN, edge with `direction_idx`=15 and `hold`=0 → DONE.
  - `moves_out`←shadow.
  - `direction_idx`←0.
- SCAN, `hold`=1: no capture, no increment, no state change.
  - The top level gates rx `stack_write` with !`hold`.
- DONE → IDLE unconditionally on the next edge.
- Knight slots 8–15 are written only by seed; shadow knight slots are always 0, so knights never relay.
- `start`/`step` in SCAN or DONE are ignored, not queued.
- `moves_out` is stable throughout SCAN; it changes only at the seed edge or the DONE-entry edge.
- Reset values, asynchronous on `rst`=0:
  - state IDLE.
  - `moves_out`=0, shadow=0.
  - `direction_idx`=0, `busy`=0, `scan_done`=0, `relay_any`=0.
- Reset mid-SCAN aborts the scan; no partial update of `moves_out`.

## Timing
- Seed latency: 1 edge; `moves_out` and `relay_any` are valid after the sampling edge.
- Scan with no hold:
  - `step` sampled at edge E0.
  - `direction_idx`=k between edges Ek and Ek+1, for k=0..15.
  - E16 enters DONE: `scan_done`=1 and the new `moves_out` is visible from E16 until E17.
  - E17 returns to IDLE.
- Each `hold` cycle during SCAN adds exactly one cycle.
- `rx_tx_valid`/`rx_tx_piece` are combinational from rx on `direction_idx` and are sampled at the same edge.
- `relay_any` is combinational from `moves_out`.
- The earliest new `step` is the edge after E17.

## Test plan
- Reset: assert `rst`=0 mid-SCAN at `direction_idx`=6.
  - Immediately: `moves_out`=0, `direction_idx`=0, `busy`=0, `scan_done`=0.
  - After release, a `step` runs a full 17-edge scan.
- Seed: `square_piece`=10'h1A5, `square_mine`=1, `start` pulse.
  - All 16 slots = 10'h1A5, `relay_any`=1, `busy`=0.
  - Repeat with `square_mine`=0 → all slots 0, `relay_any`=0.
- Relay: seed 10'h1A5, then `step`; rx drives valid with 10'h0C3 at idx 0 and 10'h0D1 at idx 5.
  - At DONE: slot2=10'h0C3, slot7=10'h0D1, all other slots 0 (seed cleared).
  - `scan_done` is a single pulse exactly 16 edges after the `step` edge.
- Knight ignore: `rx_tx_valid`=1 with 10'h2FF for idx 8–15 only.
  - At DONE `moves_out`=0 and `relay_any`=0.
- Hold: `hold`=1 for 3 cycles while idx=4, with `rx_tx_valid`=1 and 10'h0C3 at idx 4.
  - idx stays 4 for 4 cycles; slot6=10'h0C3 is written once.
  - `scan_done` arrives 19 edges after `step`.
- Collisions:
  - `start`+`step` together in IDLE → seed only, no SCAN.
  - `start` and `step` pulsed mid-SCAN → no effect; `moves_out` unchanged until DONE.
